// File: rtl/systolic_data_setup_unit.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_data_setup_unit
//  Description : Input skew stage for the systolic matrix multiply unit.
//                Lane i of each incoming row is delayed by i enabled clock
//                edges, which turns row-ordered data from the unified buffer
//                into the diagonal wavefront consumed by the array's left
//                edge. Storage is triangular: N*(N-1)/2 byte registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_data_setup_unit #(
    parameter int MATRIX_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    // Lane j occupies bits [8j+7:8j]; each lane is one tpu byte_type value.
    input  logic [MATRIX_WIDTH-1:0][7:0] data_in,
    output logic [MATRIX_WIDTH-1:0][7:0] systolic_data_out
);

    // Lane 0 has zero delay: a straight wire, unaffected by reset or enable.
    assign systolic_data_out[0] = data_in[0];

    // Lanes 1..N-1: lane i is a chain of i byte registers. w_tap[0] is the
    // lane input, w_tap[k+1] is the output of stage k, and the last tap
    // drives the lane output.
    for (genvar i = 1; i < MATRIX_WIDTH; i++) begin : g_lane
        logic [i:0][7:0] w_tap;

        assign w_tap[0] = data_in[i];

        for (genvar k = 0; k < i; k++) begin : g_stage
            logic [7:0] r_q;

            // One delay stage: advances only on enabled edges so a stall
            // freezes the whole wavefront; reset discards in-flight bytes.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= 8'h00;
                end else if (enable) begin
                    r_q <= w_tap[k];
                end
            end

            assign w_tap[k+1] = r_q;
        end : g_stage

        assign systolic_data_out[i] = w_tap[i];
    end : g_lane

endmodule : systolic_data_setup_unit
`default_nettype wire

// File: tb/tb_systolic_data_setup_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_data_setup_unit
//  Description : Directed self-checking bench for the input skew stage,
//                MATRIX_WIDTH = 10. Expected outputs come from closed-form
//                per-pattern formulas: after t enabled edges, lane j shows
//                the byte driven on lane j during cycle t-j.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_data_setup_unit;

    localparam int W = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                enable = 1'b0;
    logic [W-1:0][7:0]   data_in = '0;
    logic [W-1:0][7:0]   systolic_data_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_data_setup_unit #(.MATRIX_WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .data_in           (data_in),
        .systolic_data_out (systolic_data_out)
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic chk(input string tag, input int lane,
                       input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane %0d: got %02h, expected %02h (t=%0t)",
                     tag, lane, act, exp, $time);
        end
    endtask

    // Byte driven on lane j during enabled cycle c for each stimulus pattern.
    //   0: wavefront 5j+c+1 for c=0..4
    //   1: single 0xFF impulse at c=0
    //   2: single marker row 0xA0+j at c=0
    //   3: full-range stream over {00,80,FF}, c=0..5
    function automatic logic [7:0] row_val(input int mode, input int c, input int j);
        logic [7:0] tbl [3];
        tbl[0] = 8'h00; tbl[1] = 8'h80; tbl[2] = 8'hFF;
        row_val = 8'h00;
        if (c >= 0) begin
            case (mode)
                0: if (c <= 4) row_val = 8'(5*j + c + 1);
                1: if (c == 0) row_val = 8'hFF;
                2: if (c == 0) row_val = 8'(8'hA0 + j);
                3: if (c <= 5) row_val = tbl[(c + j) % 3];
                default: row_val = 8'h00;
            endcase
        end
    endfunction

    task automatic drive(input int mode, input int t);
        for (int j = 0; j < W; j++) data_in[j] = row_val(mode, t, j);
    endtask

    task automatic check_row(input string tag, input int mode, input int t);
        #1;
        for (int j = 0; j < W; j++)
            chk(tag, j, systolic_data_out[j], row_val(mode, t - j, j));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse asserted mid-cycle; delayed lanes must clear
    // immediately while lane 0 keeps following data_in[0].
    task automatic do_reset(input string tag, input logic [7:0] lane0_exp);
        #3;
        rst = 1'b1;
        #1;
        chk(tag, 0, systolic_data_out[0], lane0_exp);
        for (int j = 1; j < W; j++) chk(tag, j, systolic_data_out[j], 8'h00);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset with nonzero inputs and enable low.
        for (int j = 0; j < W; j++) data_in[j] = 8'(8'h11 * (j + 1));
        enable = 1'b0;
        do_reset("reset", 8'h11);

        // 2/3. Wavefront with a 3-cycle stall after the 7th enabled edge.
        enable = 1'b1;
        drive(0, 0);
        check_row("wave", 0, 0);
        for (int t = 1; t <= 15; t++) begin
            if (t == 8) begin
                enable = 1'b0;
                repeat (3) begin
                    edge_step();
                    check_row("stall", 0, 7);
                end
                enable = 1'b1;
            end
            edge_step();
            drive(0, t);
            check_row("wave", 0, t);
            if (t == 3)  chk("spot_l3_e3",  3, systolic_data_out[3], 8'd16);
            if (t == 9)  chk("spot_l9_e9",  9, systolic_data_out[9], 8'd46);
            if (t == 13) chk("spot_l9_e13", 9, systolic_data_out[9], 8'd50);
        end

        // 4. Single 0xFF impulse produces a diagonal.
        do_reset("reset_pre_impulse", 8'h00);
        drive(1, 0);
        check_row("impulse", 1, 0);
        for (int t = 1; t <= 11; t++) begin
            edge_step();
            drive(1, t);
            check_row("impulse", 1, t);
        end

        // 5. Reset while the wavefront is half propagated, then new data.
        do_reset("reset_pre_midop", 8'h00);
        drive(0, 0);
        check_row("midop_wave", 0, 0);
        for (int t = 1; t <= 4; t++) begin
            edge_step();
            drive(0, t);
            check_row("midop_wave", 0, t);
        end
        do_reset("reset_midop", 8'd5);
        drive(2, 0);
        check_row("post_reset", 2, 0);
        for (int t = 1; t <= 11; t++) begin
            edge_step();
            drive(2, t);
            check_row("post_reset", 2, t);
        end

        // 6. Full-range byte values, bit-exact with per-lane delay.
        do_reset("reset_pre_range", 8'h00);
        drive(3, 0);
        check_row("range", 3, 0);
        for (int t = 1; t <= 15; t++) begin
            edge_step();
            drive(3, t);
            check_row("range", 3, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_systolic_data_setup_unit
`default_nettype wire

// File: doc/systolic_data_setup_unit.md
Name: systolic_data_setup_unit

Overview:
Input skew stage of the TPU matrix multiply unit. Each cycle it accepts one row of MATRIX_WIDTH bytes. It delays lane i by i enabled clock cycles. The result is the diagonal, wavefront-ordered data that the systolic array's left edge consumes. It sits between the unified buffer read path and the systolic MAC array.

Parameters:
- MATRIX_WIDTH, default 14, number of byte lanes (systolic array dimension); legal range 2 to 64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all delay registers.
- enable  input  1  when high, delay registers advance on the clock edge; when low, all registers hold.
- data_in  input  MATRIX_WIDTH x 8 (packed array of byte_type)  input row; lane j occupies bits [8j+7:8j].
- systolic_data_out  output  MATRIX_WIDTH x 8 (packed array of byte_type)  skewed output row, same lane packing.

Behaviour:
- byte_type is 8-bit unsigned from tpu_pkg. No arithmetic is performed; bytes are moved bit-exactly.
- Lane 0 has zero delay: systolic_data_out[0] = data_in[0] combinationally, independent of enable and reset.
- Lane i (1 <= i < MATRIX_WIDTH) is a shift chain of i byte registers. The output is the last stage, so systolic_data_out[i] equals the data_in[i] value sampled i enabled rising edges earlier.
- Total storage is MATRIX_WIDTH*(MATRIX_WIDTH-1)/2 byte registers. The triangular structure is built with generate loops over lane and stage.
- On each rising edge with enable=1:
  - stage 0 of lane i loads data_in[i];
  - stage k loads stage k-1.
- With enable=0, every register holds its value. Delay is counted in enabled edges only, so a stall freezes the wavefront intact.
- Reset:
  - rst=1 asynchronously clears every register to 0x00.
  - While rst=1, outputs for lanes 1..MATRIX_WIDTH-1 read 0x00, and registers ignore clk and enable.
  - Lane 0 still reflects data_in[0].
- Reset mid-stream discards all in-flight bytes. After release, lane i outputs 0x00 until i enabled edges have elapsed.
- rst has priority over enable.
- No handshake, valid or flush signalling. The consumer tracks latency externally: the last lane of a row appears MATRIX_WIDTH-1 enabled cycles after the row is presented.
- No X propagation is allowed after reset; all registers have defined reset values.

Test Plan:
1. Reset: drive data_in with nonzero values, pulse rst asynchronously (mid-cycle), enable=0 -> lanes 1..N-1 read 0x00 immediately; lane 0 equals data_in[0].
2. Skew wavefront (MATRIX_WIDTH=10): after reset, enable=1. On enabled cycle c (c=0..4), drive lane j with 5j+c+1, i.e. cycle 0 = 1,6,11,...,46. Then drive zeros.
   - systolic_data_out[j] equals 5j+(t-j)+1 for t-j in 0..4, and 0x00 otherwise, where t counts enabled edges.
   - Example: lane 9 shows 46 after the 9th edge and 50 after the 13th.
   - Example: lane 3 shows 16 after the 3rd edge.
3. Stall: mid-stream, deassert enable for 3 cycles -> all outputs frozen. On re-enable, the sequence continues exactly where it stopped, with no duplicated or lost bytes.
4. Single impulse: data_in = all 0xFF for one enabled cycle, then zeros -> lane i shows 0xFF for exactly one enabled cycle, i edges after injection. This produces a diagonal of 0xFF across lanes 0..9.
5. Reset mid-operation: assert rst while the wavefront from test 2 is half propagated -> all delayed lanes clear to 0x00 at once. After release, new data emerges with the nominal i-cycle latency and no stale bytes.
6. Full-range values: stream 0x00, 0x80 and 0xFF patterns -> outputs are bit-exact copies with the per-lane delay, with no sign handling applied.
